mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters:
- BITSIZE, default 32, data/address width.
- TIMEOUT, default 255, maximum wait cycles for mem_valid_i (1..255).

REQ-002 Clock and reset: clk in 1, rising-edge clock; resetn_i in 1, reset, asynchronous, active-low.

REQ-003 Instruction-fetch port:
- IF_addr_i in BITSIZE
- IF_read_i in 1
- IF_data_o out BITSIZE
- IF_valid_o out 1

REQ-004 Data port:
- MEM_addr_i in BITSIZE
- MEM_data_i in BITSIZE, write data
- MEM_read_i in 1
- MEM_write_i in 1
- MEM_write_size_i in 2, funct3[1:0]
- MEM_data_o out BITSIZE
- MEM_valid_o out 1

REQ-005 Memory port:
- mem_addr_o out BITSIZE
- mem_wdata_o out BITSIZE
- mem_rdata_i in BITSIZE
- mem_read_o out 1
- mem_write_o out 1
- mem_size_o out 2
- mem_valid_i in 1

REQ-006 Status: err_o out 1, one-cycle pulse accompanying a timed-out response.

Function
REQ-007 FSM states: IDLE, GRANT_IF, GRANT_MEM, RESP.

REQ-008 A request is pending when:
- IF request: IF_read_i=1.
- MEM request: MEM_read_i|MEM_write_i=1.

REQ-009 IDLE arbitration:
- Only one port pending: that port is granted.
- Both pending: the port not in last_grant is granted (round-robin).
- last_grant updates on every grant.

REQ-010 At the grant edge, address, write data, size and read/write direction are latched into registers.
- IF grant: size=2'b10, read only.
- MEM_read_i and MEM_write_i both high: treated as write.

REQ-011 mem_addr_o, mem_wdata_o, mem_size_o, mem_read_o and mem_write_o are driven only from the latched registers in GRANT_* states.
- They stay stable until mem_valid_i.
- They are 0 in IDLE and RESP.

REQ-012 Requester inputs that change after the grant do not affect the transaction in flight.

REQ-013 GRANT_* with mem_valid_i=1:
- mem_rdata_i is registered into the granted port's data register; writes register 0.
- The FSM moves to RESP.

REQ-014 RESP lasts exactly one cycle:
- The granted port's valid_o=1; the other port's valid_o=0.
- The FSM then goes to IDLE.
- No arbitration occurs in RESP, so the requester's still-high request is not re-granted.

REQ-015 IF_data_o and MEM_data_o hold their last registered value until their next response.

REQ-016 Minimum latency, request in IDLE to valid_o: 2 cycles, for a memory responding in the cycle after grant.

REQ-017 Wait counter:
- 8-bit, cleared at grant, incremented each GRANT_* cycle with mem_valid_i=0.
- When it reaches TIMEOUT: the transaction is abandoned, the data register loads 0, err_o=1 in the RESP cycle, and the FSM goes to RESP.

REQ-018 mem_valid_i in IDLE or RESP is ignored.

REQ-019 If mem_valid_i and timeout coincide, mem_valid_i wins and err_o=0.

Reset
REQ-020 resetn_i=0 forces the following immediately, regardless of clock:
- state=IDLE, last_grant=IF, so the first tie goes to MEM.
- All valid, read, write, err outputs 0.
- Data, address, wdata and size registers 0, counter 0.

REQ-021 Reset asserted mid-transaction abandons it; no valid_o pulse is produced for it after reset release.

REQ-022 The first arbitration after reset release occurs at the first rising edge with resetn_i=1.

Verification
REQ-023 IF only:
- Stimulus: IF_read_i=1, IF_addr_i=0x100; memory returns 0xDEADBEEF one cycle after mem_read_o.
- Required: mem_addr_o=0x100, mem_size_o=2'b10; IF_valid_o high for one cycle with IF_data_o=0xDEADBEEF, 2 cycles after request; MEM_valid_o stays 0.

REQ-024 Tie after reset:
- Stimulus: IF_read_i and MEM_read_i both high from reset release.
- Required: MEM granted first, IF second, then alternating while both stay high; each response has exactly one valid pulse.

REQ-025 Store:
- Stimulus: MEM_write_i=1, MEM_addr_i=0x2000, MEM_data_i=0x000000AB, MEM_write_size_i=2'b00.
- Required: mem_write_o=1 with those values held stable across 3 wait cycles; MEM_valid_o pulses once.

REQ-026 Timeout with TIMEOUT=4:
- Stimulus: MEM read, mem_valid_i never asserted.
- Required: after 4 wait cycles, MEM_valid_o=1, err_o=1, MEM_data_o=0; state returns to IDLE.

REQ-027 Reset mid-operation:
- Stimulus: resetn_i pulsed low while in GRANT_IF.
- Required: mem_read_o drops asynchronously; no IF_valid_o pulse; a subsequent tie grants MEM first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: round-robin
// arbitration on ties, latched request payload, bounded wait with timeout error.
module mem_port_arbiter #(
   parameter int unsigned BITSIZE = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               resetn_i,
   // instruction-fetch port
   input  logic [BITSIZE-1:0] IF_addr_i,
   input  logic               IF_read_i,
   output logic [BITSIZE-1:0] IF_data_o,
   output logic               IF_valid_o,
   // data port
   input  logic [BITSIZE-1:0] MEM_addr_i,
   input  logic [BITSIZE-1:0] MEM_data_i,
   input  logic               MEM_read_i,
   input  logic               MEM_write_i,
   input  logic [1:0]         MEM_write_size_i,
   output logic [BITSIZE-1:0] MEM_data_o,
   output logic               MEM_valid_o,
   // memory port
   output logic [BITSIZE-1:0] mem_addr_o,
   output logic [BITSIZE-1:0] mem_wdata_o,
   input  logic [BITSIZE-1:0] mem_rdata_i,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic [1:0]         mem_size_o,
   input  logic               mem_valid_i,
   // status
   output logic               err_o
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT_IF  = 2'd1,
      GRANT_MEM = 2'd2,
      RESP      = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               last_if_q, last_if_d;
   logic [BITSIZE-1:0] addr_q, addr_d;
   logic [BITSIZE-1:0] wdata_q, wdata_d;
   logic [1:0]         size_q, size_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BITSIZE-1:0] if_data_q, if_data_d;
   logic [BITSIZE-1:0] mem_data_q, mem_data_d;
   logic               if_valid_q, if_valid_d;
   logic               mem_valid_q, mem_valid_d;
   logic               err_q, err_d;

   logic               if_req;
   logic               mem_req;
   logic               grant_mem;
   logic [BITSIZE-1:0] rsp_data;

   assign if_req    = IF_read_i;
   assign mem_req   = MEM_read_i | MEM_write_i;
   // On a tie the data port wins only if fetch was served last
   assign grant_mem = mem_req & (~if_req | last_if_q);
   // Writes and timeouts return zero data
   assign rsp_data  = (mem_valid_i && rd_q) ? mem_rdata_i : '0;

   always_comb begin
      state_d     = state_q;
      last_if_d   = last_if_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      if_data_d   = if_data_q;
      mem_data_d  = mem_data_q;
      if_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_mem) begin
               state_d   = GRANT_MEM;
               last_if_d = 1'b0;
               addr_d    = MEM_addr_i;
               wdata_d   = MEM_data_i;
               size_d    = MEM_write_size_i;
               rd_d      = ~MEM_write_i;
               wr_d      = MEM_write_i;
               cnt_d     = '0;
            end else if (if_req) begin
               state_d   = GRANT_IF;
               last_if_d = 1'b1;
               addr_d    = IF_addr_i;
               wdata_d   = '0;
               size_d    = SIZE_WORD;
               rd_d      = 1'b1;
               wr_d      = 1'b0;
               cnt_d     = '0;
            end
         end
         GRANT_IF, GRANT_MEM: begin
            if (!mem_valid_i) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // A response beats a coinciding timeout
            if (mem_valid_i || (cnt_q == LAST_WAIT)) begin
               state_d = RESP;
               err_d   = ~mem_valid_i;
               addr_d  = '0;
               wdata_d = '0;
               size_d  = '0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               if (state_q == GRANT_IF) begin
                  if_valid_d = 1'b1;
                  if_data_d  = rsp_data;
               end else begin
                  mem_valid_d = 1'b1;
                  mem_data_d  = rsp_data;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q     <= IDLE;
         last_if_q   <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         if_data_q   <= '0;
         mem_data_q  <= '0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_if_q   <= last_if_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         if_data_q   <= if_data_d;
         mem_data_q  <= mem_data_d;
         if_valid_q  <= if_valid_d;
         mem_valid_q <= mem_valid_d;
         err_q       <= err_d;
      end
   end

   // Payload registers are zeroed outside GRANT_*, so the bus reads them directly
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_size_o  = size_q;
   assign mem_read_o  = rd_q;
   assign mem_write_o = wr_q;
   assign IF_data_o   = if_data_q;
   assign IF_valid_o  = if_valid_q;
   assign MEM_data_o  = mem_data_q;
   assign MEM_valid_o = mem_valid_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned W  = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic [W-1:0]  IF_addr, MEM_addr, MEM_data, mem_rdata;
   logic          IF_read, MEM_read, MEM_write, mem_valid;
   logic [1:0]    MEM_size;
   logic [W-1:0]  IF_data_o, MEM_data_o, mem_addr_o, mem_wdata_o;
   logic          IF_valid_o, MEM_valid_o, mem_read_o, mem_write_o, err_o;
   logic [1:0]    mem_size_o;

   int checks = 0;
   int errors = 0;

   // reference model: who was served last, and the data each port should hold
   bit            m_last_if;
   logic [W-1:0]  m_if_data, m_mem_data;

   always #5 clk = ~clk;

   mem_port_arbiter #(.BITSIZE(W), .TIMEOUT(TO)) dut (
      .clk              (clk),
      .resetn_i         (resetn),
      .IF_addr_i        (IF_addr),
      .IF_read_i        (IF_read),
      .IF_data_o        (IF_data_o),
      .IF_valid_o       (IF_valid_o),
      .MEM_addr_i       (MEM_addr),
      .MEM_data_i       (MEM_data),
      .MEM_read_i       (MEM_read),
      .MEM_write_i      (MEM_write),
      .MEM_write_size_i (MEM_size),
      .MEM_data_o       (MEM_data_o),
      .MEM_valid_o      (MEM_valid_o),
      .mem_addr_o       (mem_addr_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_rdata_i      (mem_rdata),
      .mem_read_o       (mem_read_o),
      .mem_write_o      (mem_write_o),
      .mem_size_o       (mem_size_o),
      .mem_valid_i      (mem_valid),
      .err_o            (err_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      IF_addr = '0; IF_read = 1'b0;
      MEM_addr = '0; MEM_data = '0; MEM_read = 1'b0; MEM_write = 1'b0; MEM_size = 2'b00;
      mem_rdata = '0; mem_valid = 1'b0;
   endtask

   task automatic model_reset();
      m_last_if  = 1'b1;
      m_if_data  = '0;
      m_mem_data = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #2;
      checks++;
      if ({IF_valid_o, MEM_valid_o, mem_read_o, mem_write_o, err_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected 00000", {IF_valid_o, MEM_valid_o, mem_read_o, mem_write_o, err_o});
      end
      checks++;
      if ({IF_data_o, MEM_data_o, mem_addr_o, mem_wdata_o, mem_size_o} !== '0) begin
         errors++;
         $display("FAIL reset_regs got %h %h %h %h %b expected all 0", IF_data_o, MEM_data_o, mem_addr_o, mem_wdata_o, mem_size_o);
      end
      IF_read = 1'b1;
      tick(); tick();
      checks++;
      if (mem_read_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold mem_read_o got %b expected 0", mem_read_o);
      end
      IF_read = 1'b0;
      resetn  = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_if_only();
      IF_read = 1'b1; IF_addr = 32'h100;
      tick();
      checks++;
      if ({mem_read_o, mem_write_o, mem_size_o, mem_addr_o, IF_valid_o} !== {1'b1, 1'b0, 2'b10, 32'h100, 1'b0}) begin
         errors++;
         $display("FAIL if_only_grant got rd=%b wr=%b size=%b addr=%h ifv=%b expected rd=1 wr=0 size=10 addr=00000100 ifv=0",
                  mem_read_o, mem_write_o, mem_size_o, mem_addr_o, IF_valid_o);
      end
      mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      checks++;
      if ({IF_valid_o, MEM_valid_o, err_o, IF_data_o, mem_read_o} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0}) begin
         errors++;
         $display("FAIL if_only_resp got ifv=%b memv=%b err=%b data=%h rd=%b expected 1 0 0 deadbeef 0",
                  IF_valid_o, MEM_valid_o, err_o, IF_data_o, mem_read_o);
      end
      mem_valid = 1'b0; IF_read = 1'b0;
      tick();
      checks++;
      if ({IF_valid_o, MEM_valid_o, IF_data_o} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL if_only_after got ifv=%b memv=%b data=%h expected 0 0 deadbeef", IF_valid_o, MEM_valid_o, IF_data_o);
      end
      m_last_if = 1'b1;
      m_if_data = 32'hDEADBEEF;
   endtask

   task automatic test_tie();
      logic [W-1:0] rd;
      bit           exp_mem;
      resetn = 1'b0;
      IF_read = 1'b1; IF_addr = 32'h1000;
      MEM_read = 1'b1; MEM_addr = 32'h2000; MEM_size = 2'b01;
      tick();
      resetn = 1'b1;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_mem = m_last_if;
         checks++;
         if ({mem_read_o, mem_addr_o} !== {1'b1, exp_mem ? 32'h2000 : 32'h1000}) begin
            errors++;
            $display("FAIL tie_grant[%0d] got rd=%b addr=%h expected rd=1 addr=%h", i, mem_read_o, mem_addr_o,
                     exp_mem ? 32'h2000 : 32'h1000);
         end
         repeat ($urandom_range(0, 2)) tick();
         rd = $urandom | 32'h1;
         mem_valid = 1'b1; mem_rdata = rd;
         tick();
         mem_valid = 1'b0;
         if (exp_mem) m_mem_data = rd; else m_if_data = rd;
         m_last_if = !exp_mem;
         checks++;
         if ({IF_valid_o, MEM_valid_o, IF_data_o, MEM_data_o} !== {!exp_mem, exp_mem, m_if_data, m_mem_data}) begin
            errors++;
            $display("FAIL tie_resp[%0d] got ifv=%b memv=%b if=%h mem=%h expected %b %b %h %h", i, IF_valid_o, MEM_valid_o,
                     IF_data_o, MEM_data_o, !exp_mem, exp_mem, m_if_data, m_mem_data);
         end
         tick();
         checks++;
         if ({IF_valid_o, MEM_valid_o, mem_read_o} !== 3'b000) begin
            errors++;
            $display("FAIL tie_idle[%0d] got %b expected 000", i, {IF_valid_o, MEM_valid_o, mem_read_o});
         end
      end
      IF_read = 1'b0; MEM_read = 1'b0;
   endtask

   task automatic test_timeout();
      MEM_read = 1'b1; MEM_addr = 32'h3000;
      tick();
      m_last_if = 1'b0;
      for (int k = 1; k <= int'(TO); k++) begin
         checks++;
         if ({mem_read_o, MEM_valid_o, err_o} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_wait[%0d] got rd=%b memv=%b err=%b expected 1 0 0", k, mem_read_o, MEM_valid_o, err_o);
         end
         tick();
      end
      m_mem_data = '0;
      checks++;
      if ({MEM_valid_o, IF_valid_o, err_o, MEM_data_o, IF_data_o, mem_read_o} !== {1'b1, 1'b0, 1'b1, 32'h0, m_if_data, 1'b0}) begin
         errors++;
         $display("FAIL timeout_resp got memv=%b ifv=%b err=%b mem=%h if=%h rd=%b expected 1 0 1 00000000 %h 0",
                  MEM_valid_o, IF_valid_o, err_o, MEM_data_o, IF_data_o, mem_read_o, m_if_data);
      end
      MEM_read = 1'b0;
      tick();
      checks++;
      if ({MEM_valid_o, err_o, mem_read_o} !== 3'b000) begin
         errors++;
         $display("FAIL timeout_idle got %b expected 000", {MEM_valid_o, err_o, mem_read_o});
      end
   endtask

   task automatic test_store();
      MEM_write = 1'b1; MEM_addr = 32'h2000; MEM_data = 32'h000000AB; MEM_size = 2'b00;
      tick();
      m_last_if = 1'b0;
      // requester changes its mind after the grant; bus must not follow
      MEM_write = 1'b0; MEM_read = 1'b1; MEM_addr = $urandom; MEM_data = $urandom; MEM_size = 2'b11;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o, mem_size_o, MEM_valid_o} !==
             {1'b1, 1'b0, 32'h2000, 32'h000000AB, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL store_hold[%0d] got wr=%b rd=%b addr=%h wdata=%h size=%b memv=%b expected 1 0 00002000 000000ab 00 0",
                     k, mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o, mem_size_o, MEM_valid_o);
         end
         if (k == 3) mem_valid = 1'b1;
         mem_rdata = $urandom;
         tick();
      end
      mem_valid = 1'b0; MEM_read = 1'b0;
      m_mem_data = '0;
      checks++;
      if ({MEM_valid_o, err_o, MEM_data_o, mem_write_o} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL store_resp got memv=%b err=%b data=%h wr=%b expected 1 0 00000000 0", MEM_valid_o, err_o, MEM_data_o, mem_write_o);
      end
      tick();
      checks++;
      if (MEM_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL store_single_pulse memv got %b expected 0", MEM_valid_o);
      end
   endtask

   task automatic test_reset_mid();
      IF_read = 1'b1; IF_addr = 32'h300;
      tick();
      checks++;
      if ({mem_read_o, mem_addr_o} !== {1'b1, 32'h300}) begin
         errors++;
         $display("FAIL rstmid_grant got rd=%b addr=%h expected 1 00000300", mem_read_o, mem_addr_o);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({mem_read_o, IF_valid_o, mem_addr_o} !== {1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL rstmid_async got rd=%b ifv=%b addr=%h expected 0 0 00000000", mem_read_o, IF_valid_o, mem_addr_o);
      end
      MEM_read = 1'b1; MEM_addr = 32'h400; mem_valid = 1'b1; mem_rdata = 32'h12345678;
      tick();
      resetn = 1'b1; mem_valid = 1'b0;
      model_reset();
      tick();
      checks++;
      if ({mem_read_o, mem_addr_o, IF_valid_o} !== {1'b1, 32'h400, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_tie got rd=%b addr=%h ifv=%b expected 1 00000400 0", mem_read_o, mem_addr_o, IF_valid_o);
      end
      mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0; IF_read = 1'b0; MEM_read = 1'b0;
      m_last_if = 1'b0; m_mem_data = 32'h12345678;
      checks++;
      if ({MEM_valid_o, IF_valid_o, MEM_data_o, IF_data_o} !== {1'b1, 1'b0, 32'h12345678, 32'h0}) begin
         errors++;
         $display("FAIL rstmid_resp got memv=%b ifv=%b mem=%h if=%h expected 1 0 12345678 00000000",
                  MEM_valid_o, IF_valid_o, MEM_data_o, IF_data_o);
      end
      tick();
   endtask

   task automatic test_random();
      bit           ifr, mr, mw, g_mem, timed_out, done;
      int           lat, sel;
      logic [W-1:0] ia, ma, md, rd, exp_addr, exp_wd;
      logic [1:0]   sz, exp_size;
      logic         exp_rd, exp_wr;
      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 3);
         ifr = (sel == 1) || (sel == 3);
         mr = 1'b0; mw = 1'b0;
         if (sel >= 2) begin
            case ($urandom_range(0, 2))
               0:       mr = 1'b1;
               1:       mw = 1'b1;
               default: begin mr = 1'b1; mw = 1'b1; end
            endcase
         end
         ia = $urandom; ma = $urandom; md = $urandom; sz = 2'($urandom_range(0, 3));
         IF_read = ifr; IF_addr = ia; MEM_read = mr; MEM_write = mw; MEM_addr = ma; MEM_data = md; MEM_size = sz;
         mem_valid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         tick();
         if (!ifr && !mr && !mw) begin
            checks++;
            if ({mem_read_o, mem_write_o, IF_valid_o, MEM_valid_o} !== 4'b0000) begin
               errors++;
               $display("FAIL rnd_idle[%0d] got %b expected 0000", it, {mem_read_o, mem_write_o, IF_valid_o, MEM_valid_o});
            end
            continue;
         end
         g_mem     = (mr || mw) && (!ifr || m_last_if);
         m_last_if = !g_mem;
         exp_rd    = g_mem ? !mw : 1'b1;
         exp_wr    = g_mem ? mw : 1'b0;
         exp_size  = g_mem ? sz : 2'b10;
         exp_addr  = g_mem ? ma : ia;
         exp_wd    = (g_mem && mw) ? md : 32'h0;
         lat       = $urandom_range(0, 5);
         rd        = $urandom;
         timed_out = 1'b0;
         for (int k = 1; k <= int'(TO); k++) begin
            checks++;
            if ({mem_read_o, mem_write_o, mem_size_o, mem_addr_o, exp_wr ? mem_wdata_o : 32'h0} !==
                {exp_rd, exp_wr, exp_size, exp_addr, exp_wd}) begin
               errors++;
               $display("FAIL rnd_bus[%0d.%0d] got rd=%b wr=%b size=%b addr=%h wdata=%h expected %b %b %b %h %h", it, k,
                        mem_read_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o, exp_rd, exp_wr, exp_size, exp_addr, exp_wd);
            end
            IF_read = 1'($urandom_range(0, 1)); IF_addr = $urandom;
            MEM_read = 1'($urandom_range(0, 1)); MEM_write = 1'($urandom_range(0, 1));
            MEM_addr = $urandom; MEM_data = $urandom; MEM_size = 2'($urandom_range(0, 3));
            mem_valid = (k == lat + 1);
            mem_rdata = mem_valid ? rd : $urandom;
            done      = (k == lat + 1) || (k == int'(TO));
            timed_out = (k != lat + 1) && (k == int'(TO));
            tick();
            if (done) break;
         end
         if (g_mem) m_mem_data = (timed_out || !exp_rd) ? 32'h0 : rd;
         else       m_if_data  = timed_out ? 32'h0 : rd;
         checks++;
         if ({IF_valid_o, MEM_valid_o, err_o, IF_data_o, MEM_data_o, mem_read_o, mem_write_o} !==
             {!g_mem, g_mem, timed_out, m_if_data, m_mem_data, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rnd_resp[%0d] got ifv=%b memv=%b err=%b if=%h mem=%h rd=%b wr=%b expected %b %b %b %h %h 0 0", it,
                     IF_valid_o, MEM_valid_o, err_o, IF_data_o, MEM_data_o, mem_read_o, mem_write_o,
                     !g_mem, g_mem, timed_out, m_if_data, m_mem_data);
         end
         mem_valid = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if ({IF_valid_o, MEM_valid_o, err_o, mem_read_o, mem_write_o} !== 5'b00000) begin
            errors++;
            $display("FAIL rnd_after[%0d] got %b expected 00000", it, {IF_valid_o, MEM_valid_o, err_o, mem_read_o, mem_write_o});
         end
      end
      clear_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_if_only();
      test_tie();
      test_timeout();
      test_store();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
